dff_piso_tx: RTL and testbench
==============================

Name: dff_piso_tx

Overview:
- Parallel-in/serial-out transmitter built on clocked D-register stages.
- Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clk cycle, with a frame marker on the first bit.
- Drives the serial side of the cs/dff register chain, so the inverse serial-capture path has a matching source under test.

Parameters:
- WIDTH, 8, data bits per frame (2..32).
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  WIDTH  word to transmit.
- load_ready  output  1  block accepts a word this cycle.
- ser_out  output  1  serial data bit (registered).
- ser_valid  output  1  ser_out carries a frame bit this cycle (registered).
- frame_start  output  1  high on the first bit of each frame only (registered).
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst=1 at rising clk): state=IDLE, shift register=0, bit counter=0, ser_out=0, ser_valid=0, frame_start=0, busy=0.
- load_ready is combinational and forced to 0 while rst=1.
- States:
  - IDLE: load_ready=1. On load_valid & load_ready, go to SHIFT.
  - SHIFT: one bit out per cycle.
  - PARITY: present only with PARITY_EN; one cycle.
- Accept (load_valid & load_ready at edge N):
  - load_data goes into the shift register; counter=0.
  - At cycle N+1, ser_out=first bit, ser_valid=1, frame_start=1.
  - Latency is exactly 1 cycle from accept to first bit.
- SHIFT:
  - Each edge advances one bit; counter increments 0..WIDTH-1.
  - Bit k of the frame appears at cycle N+1+k.
  - frame_start=0 after the first bit.
- Last data bit (counter==WIDTH-1, no parity):
  - load_ready=1 in that cycle.
  - If load_valid=1, the next word is accepted and its first bit follows with no gap; frame_start=1 again, state stays SHIFT.
  - Otherwise go to IDLE; ser_valid=0 and ser_out=0 next cycle.
- load_ready=0 in all other SHIFT cycles. load_valid there is ignored; the word is not consumed and the data is not sampled.
- Bit order:
  - MSB_FIRST=1: shift left, transmit the top bit.
  - MSB_FIRST=0: shift right, transmit bit 0.
  - Vacated bits fill with 0.
- Counter width: $clog2(WIDTH+1). No wrap: the counter resets to 0 on every accept.
- rst mid-frame: frame aborted; next-cycle outputs are the reset values; no partial bits afterwards.
- rst and load_valid in the same cycle: rst wins; the word is not accepted.
- load_data changing while load_ready=0: no effect.

Optional Feature:
- Macro: DFF_PISO_TX_PARITY_EN
- Defined:
  - After the last data bit, the PARITY state emits one extra bit: even parity (XOR of the loaded word), with ser_valid=1 and frame_start=0.
  - Frame length is WIDTH+1 cycles.
  - load_ready goes high in the PARITY cycle instead of on the last data bit; back-to-back works from there.
- Undefined:
  - No PARITY state; frame length is WIDTH cycles.
  - Parity logic is absent from the netlist.

Test Plan:
- Reset then idle, rst=1 for 2 cycles then 0:
  - During reset: load_ready=0, ser_valid=0, ser_out=0, busy=0.
  - First cycle after reset: load_ready=1.
- Single frame, WIDTH=8, MSB_FIRST=1, load 8'hA5 at edge N:
  - Cycles N+1..N+8: ser_out=1,0,1,0,0,1,0,1; ser_valid=1; frame_start=1 only at N+1.
  - N+9: ser_valid=0, busy=0.
  - With parity defined: N+9 carries ser_out=0 (A5 has even weight), then idle at N+10.
- LSB-first, MSB_FIRST=0, load 8'h01:
  - ser_out=1 at N+1, then 0 for N+2..N+8.
- Back-to-back: hold load_valid=1 with 8'hFF then 8'h00:
  - Second accept occurs on the last bit of the first frame.
  - 16 contiguous ser_valid=1 cycles: eight 1s then eight 0s.
  - frame_start pulses at bits 1 and 9.
- Mid-frame reset: load 8'hFF, assert rst at bit 3:
  - Next cycle ser_valid=0, ser_out=0, busy=0.
  - After rst deasserts, a new load 8'h80 transmits cleanly starting 1,0,0,...
- Load ignored while busy: pulse load_valid with 8'h3C at bit 4 of frame 8'hF0:
  - Frame 8'hF0 completes unchanged; no second frame is emitted.

Source files
------------

// File: rtl/dff_piso_tx.sv
// ============================================================================
// dff_piso_tx
// ----------------------------------------------------------------------------
// Parallel-in / serial-out transmitter built from clocked D-register stages.
// A WIDTH-bit word is taken through a valid/ready load handshake and shifted
// out one bit per clk cycle. The first bit of every frame carries a
// frame_start marker, so a downstream serial-capture chain can align itself.
//
// Parameters:
//   WIDTH      data bits per frame (2..32)
//   MSB_FIRST  1 = bit WIDTH-1 goes out first, 0 = bit 0 goes out first
//
// Optional feature (compile-time macro):
//   DFF_PISO_TX_PARITY_EN  when defined, every frame is followed by one even
//                          parity bit (XOR of the loaded word), making the
//                          frame WIDTH+1 cycles long. When undefined the
//                          parity state and its register do not exist.
//
// Ports:
//   clk          single clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   load_valid   load_data is valid this cycle
//   load_data    word to transmit (WIDTH bits)
//   load_ready   block takes a word this cycle (combinational, 0 during rst)
//   ser_out      serial data bit (registered)
//   ser_valid    ser_out carries a frame bit this cycle (registered)
//   frame_start  high on the first bit of each frame only (registered)
//   busy         state is not IDLE
// ============================================================================
module dff_piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

    // Counter is sized to hold 0..WIDTH; it never wraps because every accept
    // clears it back to zero.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef DFF_PISO_TX_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif

    logic [1:0]       state;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shifted;
    logic             first_bit;
    logic             next_bit;
    logic             at_last_bit;
    logic             handoff_slot;
    logic             accept;

`ifdef DFF_PISO_TX_PARITY_EN
    logic             parity_bit;
`endif

    // The shift register always holds the word with the bit currently on
    // ser_out in its "transmit" position (top for MSB-first, bottom for
    // LSB-first). The bit that will appear next cycle is therefore the
    // transmit position of the shifted word; vacated bits fill with zero.
    always_comb begin
        shifted   = '0;
        first_bit = 1'b0;
        next_bit  = 1'b0;
        if (MSB_FIRST) begin
            shifted   = {shift_reg[WIDTH-2:0], 1'b0};
            first_bit = load_data[WIDTH-1];
            next_bit  = shifted[WIDTH-1];
        end else begin
            shifted   = {1'b0, shift_reg[WIDTH-1:1]};
            first_bit = load_data[0];
            next_bit  = shifted[0];
        end
    end

    // A new word may be taken while still busy only in the final cycle of
    // a frame, which lets back-to-back words stream with no idle gap. With
    // parity enabled that final cycle is the parity bit, not the last data
    // bit. Reset forces ready low so a word offered during rst is never
    // considered consumed.
    always_comb begin
        at_last_bit = (state == ST_SHIFT) && (bit_cnt == LAST_BIT);
`ifdef DFF_PISO_TX_PARITY_EN
        handoff_slot = (state == ST_PARITY);
`else
        handoff_slot = at_last_bit;
`endif
        load_ready = !rst && ((state == ST_IDLE) || handoff_slot);
        accept     = load_valid && load_ready;
        busy       = (state != ST_IDLE);
    end

    // Main sequencer. An accept always wins over the normal state progress:
    // it reloads the word, restarts the counter and puts the first bit on
    // the line at the very next cycle (one cycle of latency), whether the
    // block was idle or finishing the previous frame. Otherwise SHIFT walks
    // one bit per cycle and, after the last bit, either emits the parity
    // bit or drops back to IDLE with the line quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
`ifdef DFF_PISO_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else if (accept) begin
            state       <= ST_SHIFT;
            shift_reg   <= load_data;
            bit_cnt     <= '0;
            ser_out     <= first_bit;
            ser_valid   <= 1'b1;
            frame_start <= 1'b1;
`ifdef DFF_PISO_TX_PARITY_EN
            parity_bit  <= ^load_data;
`endif
        end else begin
            frame_start <= 1'b0;
            case (state)
                ST_SHIFT: begin
                    if (at_last_bit) begin
`ifdef DFF_PISO_TX_PARITY_EN
                        state     <= ST_PARITY;
                        ser_out   <= parity_bit;
                        ser_valid <= 1'b1;
`else
                        state     <= ST_IDLE;
                        ser_out   <= 1'b0;
                        ser_valid <= 1'b0;
`endif
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                    end else begin
                        shift_reg <= shifted;
                        bit_cnt   <= bit_cnt + CNT_ONE;
                        ser_out   <= next_bit;
                        ser_valid <= 1'b1;
                    end
                end
`ifdef DFF_PISO_TX_PARITY_EN
                ST_PARITY: begin
                    state     <= ST_IDLE;
                    ser_out   <= 1'b0;
                    ser_valid <= 1'b0;
                end
`endif
                default: begin
                    // IDLE, plus recovery from any unused encoding.
                    state     <= ST_IDLE;
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                    ser_out   <= 1'b0;
                    ser_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_piso_tx.sv
// ============================================================================
// tb_dff_piso_tx
// ----------------------------------------------------------------------------
// Directed bench for dff_piso_tx. One MSB-first instance carries most of the
// scenarios; a second, LSB-first instance checks the opposite bit order.
// Expected bit streams are derived from the loaded words inside the bench.
// ============================================================================
module tb_dff_piso_tx;

`ifdef DFF_PISO_TX_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       frame_start;
    logic       busy;

    logic       lsb_load_valid;
    logic [7:0] lsb_load_data;
    logic       lsb_load_ready;
    logic       lsb_ser_out;
    logic       lsb_ser_valid;
    logic       lsb_frame_start;
    logic       lsb_busy;

    int checks;
    int failures;

    dff_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .busy        (busy)
    );

    dff_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (lsb_load_valid),
        .load_data   (lsb_load_data),
        .load_ready  (lsb_load_ready),
        .ser_out     (lsb_ser_out),
        .ser_valid   (lsb_ser_valid),
        .frame_start (lsb_frame_start),
        .busy        (lsb_busy)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive the main instance inputs, then move to 1 unit after the next edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
        rst        = r;
        load_valid = v;
        load_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Called in the first cycle after an accept on the MSB-first instance.
    // Walks the whole frame, optionally offering a stray word at pulse_idx,
    // and finishes one cycle into idle.
    task automatic checkFrame(input string tag, input logic [7:0] word,
                              input int pulse_idx, input logic [7:0] pulse_data);
        for (int k = 0; k < 8; k++) begin
            checkOutput({tag, "_bit"},    32'(ser_out),     32'(word[7-k]));
            checkOutput({tag, "_valid"},  32'(ser_valid),   32'd1);
            checkOutput({tag, "_fstart"}, 32'(frame_start), 32'(k == 0));
            checkOutput({tag, "_ready"},  32'(load_ready),  32'(FL == 8 && k == 7));
            if (k == pulse_idx)
                applyStimulus(1'b0, 1'b1, pulse_data);
            else
                applyStimulus(1'b0, 1'b0, 8'h00);
        end
`ifdef DFF_PISO_TX_PARITY_EN
        checkOutput({tag, "_parity"},   32'(ser_out),     32'(^word));
        checkOutput({tag, "_par_valid"}, 32'(ser_valid),  32'd1);
        checkOutput({tag, "_par_fstart"}, 32'(frame_start), 32'd0);
        checkOutput({tag, "_par_ready"}, 32'(load_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00);
`endif
        checkOutput({tag, "_end_valid"}, 32'(ser_valid), 32'd0);
        checkOutput({tag, "_end_out"},   32'(ser_out),   32'd0);
        checkOutput({tag, "_end_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        logic [7:0] lsb_word;
        checks         = 0;
        failures       = 0;
        lsb_load_valid = 1'b0;
        lsb_load_data  = 8'h00;

        // Reset held for two cycles.
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("rst_ready",  32'(load_ready),  32'd0);
        checkOutput("rst_valid",  32'(ser_valid),   32'd0);
        checkOutput("rst_out",    32'(ser_out),     32'd0);
        checkOutput("rst_busy",   32'(busy),        32'd0);
        checkOutput("rst_fstart", 32'(frame_start), 32'd0);
        checkOutput("rst_lsb_busy", 32'(lsb_busy),  32'd0);
        rst = 1'b0;
        #1;
        checkOutput("idle_ready",     32'(load_ready),     32'd1);
        checkOutput("idle_lsb_ready", 32'(lsb_load_ready), 32'd1);

        // Single MSB-first frame of 8'hA5.
        applyStimulus(1'b0, 1'b1, 8'hA5);
        checkOutput("a5_busy", 32'(busy), 32'd1);
        checkFrame("a5", 8'hA5, -1, 8'h00);

        // LSB-first frame of 8'h01 on the second instance.
        lsb_word       = 8'h01;
        lsb_load_valid = 1'b1;
        lsb_load_data  = lsb_word;
        applyStimulus(1'b0, 1'b0, 8'h00);
        lsb_load_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checkOutput("lsb_bit",    32'(lsb_ser_out),     32'(lsb_word[k]));
            checkOutput("lsb_valid",  32'(lsb_ser_valid),   32'd1);
            checkOutput("lsb_fstart", 32'(lsb_frame_start), 32'(k == 0));
            applyStimulus(1'b0, 1'b0, 8'h00);
        end
`ifdef DFF_PISO_TX_PARITY_EN
        checkOutput("lsb_parity", 32'(lsb_ser_out), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00);
`endif
        checkOutput("lsb_end_valid", 32'(lsb_ser_valid), 32'd0);
        checkOutput("lsb_end_busy",  32'(lsb_busy),      32'd0);

        // Back-to-back 8'hFF then 8'h00 with load_valid held high.
        applyStimulus(1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 2 * FL; i++) begin
            checkOutput("b2b_valid",  32'(ser_valid),   32'd1);
            checkOutput("b2b_bit",    32'(ser_out),     32'(i < 8));
            checkOutput("b2b_fstart", 32'(frame_start), 32'(i == 0 || i == FL));
            if (i == FL - 1)
                checkOutput("b2b_handoff_ready", 32'(load_ready), 32'd1);
            applyStimulus(1'b0, i < FL, 8'h00);
        end
        checkOutput("b2b_end_valid", 32'(ser_valid), 32'd0);
        checkOutput("b2b_end_busy",  32'(busy),      32'd0);

        // Mid-frame reset on the third bit, with a word offered under reset.
        applyStimulus(1'b0, 1'b1, 8'hFF);
        checkOutput("mid_bit0", 32'(ser_out), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("mid_bit1", 32'(ser_out), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("mid_bit2", 32'(ser_out), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready", 32'(load_ready), 32'd0);
        applyStimulus(1'b1, 1'b1, 8'h55);
        checkOutput("mid_rst_valid",  32'(ser_valid),   32'd0);
        checkOutput("mid_rst_out",    32'(ser_out),     32'd0);
        checkOutput("mid_rst_busy",   32'(busy),        32'd0);
        checkOutput("mid_rst_fstart", 32'(frame_start), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("post_rst_idle_valid", 32'(ser_valid), 32'd0);
        checkOutput("post_rst_idle_busy",  32'(busy),      32'd0);
        applyStimulus(1'b0, 1'b1, 8'h80);
        checkFrame("post_rst", 8'h80, -1, 8'h00);

        // Stray load offered mid-frame must be ignored.
        applyStimulus(1'b0, 1'b1, 8'hF0);
        checkFrame("ignore", 8'hF0, 3, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            checkOutput("ignore_no_frame", 32'(ser_valid), 32'd0);
            checkOutput("ignore_no_busy",  32'(busy),      32'd0);
            applyStimulus(1'b0, 1'b0, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
